seq_alu: RTL
============

Name: seq_alu

Overview:
Parametrised, registered successor to the team's combinational 8-bit ALU. Accepts one operation per transaction over a valid/ready handshake and returns a registered result with zero, carry and negative flags. Keeps a persistent carry flag for add-with-carry chaining. Supports an optional multi-cycle shift-add multiplier. Sits between the datapath register file and the writeback stage of the teaching CPU.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 4..32).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept a request (high only in IDLE)
op  input  3  operation code, sampled on accept
a  input  WIDTH  operand A, sampled on accept
b  input  WIDTH  operand B, sampled on accept
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts the result
result  output  WIDTH  registered result
flag_zero  output  1  result == 0
flag_carry  output  1  stored carry/borrow flag
flag_neg  output  1  result[WIDTH-1]
busy  output  1  high in BUSY (multiply in progress)

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; result=0; flag_zero/flag_carry/flag_neg=0; out_valid=0; busy=0; in_ready=1 from the first cycle after reset. Reset overrides all other activity, including a multiply in progress, and no out_valid is produced for an aborted operation.
- State IDLE: in_ready=1. Accept occurs when in_valid & in_ready. Any op other than 111 computes and registers result and flags, then moves to DONE, so out_valid rises on the clk edge after accept (latency 1). Op 111 moves to BUSY when ALU_MUL_EN is defined.
- State BUSY: in_ready=0, busy=1. Runs a shift-add over exactly WIDTH cycles, then registers result and flags and moves to DONE. Accept-to-out_valid latency is WIDTH+1.
- State DONE: out_valid=1, in_ready=0. result and flags hold stable until out_ready=1. On the out_ready edge the block returns to IDLE and out_valid falls. A new request is accepted no earlier than the following cycle, so maximum throughput is 1 op per 2 cycles.
- Ops (all arithmetic is modulo 2^WIDTH, unsigned):
  - 000 ADD: A+B; carry = bit WIDTH of the sum.
  - 001 SUB: A-B; carry = borrow = (A<B).
  - 010 AND: A&B; carry unchanged.
  - 011 OR: A|B; carry unchanged.
  - 100 NOT: ~A; carry unchanged.
  - 101 XOR: A^B; carry unchanged.
  - 110 ADC: A+B+flag_carry, using the stored carry value at accept time; carry = bit WIDTH.
  - 111 MUL: see Optional Feature.
- flag_zero and flag_neg are updated for every op from the new result.
- Inputs a, b and op are ignored except on the accept cycle.
- Simultaneous in_valid and out_ready while in DONE: only the result is consumed. The request waits, because in_ready=0.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: op 111 is a multi-cycle unsigned multiply through BUSY, taking WIDTH cycles. result = low WIDTH bits of A*B. carry = 1 if the upper WIDTH bits of the product are nonzero.
- Undefined: op 111 behaves like an undefined op. result=0, flag_zero=1, flag_neg=0, carry unchanged, latency 1, and BUSY is never entered (busy tied 0).

Test Plan:
- WIDTH=8, reset, then ADD a=200 b=100 -> out_valid 1 cycle after accept; result=44, carry=1, zero=0, neg=0.
- Immediately follow with ADC a=1 b=1 -> result=3 (uses carry=1), carry=0; then AND a=0xF0 b=0x0F -> result=0, zero=1, carry=0 (unchanged).
- SUB a=5 b=7 -> result=0xFE, carry(borrow)=1, neg=1; SUB a=7 b=7 -> result=0, zero=1, carry=0.
- With ALU_MUL_EN: MUL a=13 b=11 -> in_ready=0 and busy=1 for 8 cycles, out_valid at accept+9, result=143 (0x8F), neg=1, carry=0. MUL a=255 b=2 -> result=0xFE, carry=1. Without the macro: MUL -> result=0, zero=1, latency 1, busy never 1.
- Hold out_ready=0 for 3 cycles in DONE with in_valid=1 and changing a/b -> result and flags stable, in_ready=0, no accept. Release out_ready -> IDLE next cycle, then the pending request is accepted.
- Assert rst for 1 cycle during BUSY (cycle 4 of a MUL) -> next cycle: IDLE, out_valid=0, result=0, all flags 0, in_ready=1, and no late result appears.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a valid/ready request side and a valid/ready
// result side. Returns the result with zero, carry and negative flags. The
// carry flag persists between operations so ADC can chain multi-word adds.
// Optional feature macro: ALU_MUL_EN adds a WIDTH-cycle shift-add unsigned
// multiply on op 111. Without it, op 111 yields result 0 with latency 1.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_neg,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_BUSY = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_ADC = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [1:0]         state;
  logic               accept;
  logic               start_mul;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic [WIDTH-1:0]   load_res;
  logic               load_carry;
  logic               load_en;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && (state == S_IDLE);

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign start_mul = accept && (op == OP_MUL);
  // Product including the current step, so the last BUSY cycle can register
  // the finished value directly.
  assign mul_prod  = acc + (mplier[0] ? mcand : '0);
  assign mul_last  = (state == S_BUSY) && (cnt == CW'(WIDTH - 1));
  assign busy      = (state == S_BUSY);

  // Shift-add datapath: one multiplier bit per BUSY cycle, LSB first.
  // NOTE: these working registers carry no reset; they are always loaded on
  // accept before use, and a reset only needs to clear the visible state.
  always_ff @(posedge clk) begin
    if (start_mul) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == S_BUSY) begin
      acc    <= mul_prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end
`else
  assign start_mul = 1'b0;
  assign mul_last  = 1'b0;
  assign mul_prod  = '0;
  assign busy      = 1'b0;
`endif

  // Single-cycle ALU evaluated on the live operands; used only on accept.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    sum_ext   = '0;
    alu_res   = '0;
    alu_carry = flag_carry;
    case (op)
      OP_ADD: begin
        sum_ext   = {1'b0, a} + {1'b0, b};
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      OP_SUB: begin
        sum_ext   = {1'b0, a} - {1'b0, b};
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_NOT: alu_res = ~a;
      OP_XOR: alu_res = a ^ b;
      OP_ADC: begin
        sum_ext   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, flag_carry};
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      OP_MUL: alu_res = '0;
    endcase
  end

  // Pick what gets written into the result register: multiplier on its last
  // step, otherwise the single-cycle ALU.
  always_comb begin
    load_res   = alu_res;
    load_carry = alu_carry;
    if (state == S_BUSY) begin
      load_res   = mul_prod[WIDTH-1:0];
      load_carry = |mul_prod[2*WIDTH-1:WIDTH];
    end
  end

  assign load_en = (accept && !start_mul) || mul_last;

  // Control FSM: IDLE -> (BUSY ->) DONE -> IDLE on out_ready.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_mul)   state <= S_BUSY;
          else if (accept) state <= S_DONE;
        end
        S_BUSY: if (mul_last)  state <= S_DONE;
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Result and flag registers; held through DONE until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      result     <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_neg   <= 1'b0;
    end else if (load_en) begin
      result     <= load_res;
      flag_zero  <= (load_res == '0);
      flag_carry <= load_carry;
      flag_neg   <= load_res[WIDTH-1];
    end
  end

endmodule
